// File: rtl/counter_nbit_updown.sv
// counter_nbit_updown: parametrised synchronous up/down counter with
// parallel load, wrap or saturate at the terminal value, and a
// combinational terminal-count output that can drive the next stage's enable.
// Optional build macro: CNT_STICKY_OVF_EN makes ovf sticky until clr or ovf_clr.
// Without it, ovf is a one-cycle pulse on the edge after tc.
module counter_nbit_updown #(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 64,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // MOD_EXT is one bit wider so MODULUS == 2**WIDTH still compares exactly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam bit               SAT     = (SATURATE != 0);

  logic             at_term;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_step;

  // Terminal value follows up_dn combinationally.
  assign at_term      = up_dn ? (count == TOP) : (count == '0);
  assign tc           = enable & ~load & ~clr & at_term;
  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? TOP : load_val;

  // Next value for a counting edge; wrap by explicit compare, never by overflow.
  always_comb begin
    count_step = count;
    if (at_term) begin
      if (SAT)        count_step = count;
      else if (up_dn) count_step = '0;
      else            count_step = TOP;
    end else if (up_dn) begin
      count_step = count + 1'b1;
    end else begin
      count_step = count - 1'b1;
    end
  end

  // Count register: clr > load > enable > hold.
  always_ff @(posedge clk) begin
    if (clr)         count <= '0;
    else if (load)   count <= load_clamped;
    else if (enable) count <= count_step;
  end

`ifdef CNT_STICKY_OVF_EN
  // Sticky overflow: set by tc, cleared by clr or ovf_clr; clear wins on a tie.
  always_ff @(posedge clk) begin
    if (clr || ovf_clr) ovf <= 1'b0;
    else if (tc)        ovf <= 1'b1;
  end
`else
  // One-cycle overflow pulse on the edge after tc; ovf_clr has no role here.
  always_ff @(posedge clk) begin
    if (clr) ovf <= 1'b0;
    else     ovf <= tc;
  end

  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_counter_nbit_updown.sv
// Bench for counter_nbit_updown: three instances (A default, B WIDTH=4
// MODULUS=10 wrap, C WIDTH=4 MODULUS=10 saturate) against a modulo-arithmetic
// model, plus directed literal expectations.
module tb_counter_nbit_updown;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic [2:0] clr, enable, load, up_dn, ovf_clr, tc, ovf;
  logic [5:0] lv_a, count_a;
  logic [3:0] lv_b, lv_c, count_b, count_c;

  int errors = 0;
  int checks = 0;

  counter_nbit_updown u_a (
    .clk(clk), .clr(clr[0]), .enable(enable[0]), .load(load[0]), .load_val(lv_a),
    .up_dn(up_dn[0]), .ovf_clr(ovf_clr[0]), .count(count_a), .tc(tc[0]), .ovf(ovf[0]));

  counter_nbit_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_b (
    .clk(clk), .clr(clr[1]), .enable(enable[1]), .load(load[1]), .load_val(lv_b),
    .up_dn(up_dn[1]), .ovf_clr(ovf_clr[1]), .count(count_b), .tc(tc[1]), .ovf(ovf[1]));

  counter_nbit_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_c (
    .clk(clk), .clr(clr[2]), .enable(enable[2]), .load(load[2]), .load_val(lv_c),
    .up_dn(up_dn[2]), .ovf_clr(ovf_clr[2]), .count(count_c), .tc(tc[2]), .ovf(ovf[2]));

  // ---------------- model ----------------
  int m_cnt[3];
  int m_ovf[3];
  bit m_vld[3];

  function automatic int mod_of(int i);
    return (i == 0) ? 64 : 10;
  endfunction

  function automatic bit sat_of(int i);
    return (i == 2);
  endfunction

  function automatic int lv_of(int i);
    case (i)
      0:       return int'(lv_a);
      1:       return int'(lv_b);
      default: return int'(lv_c);
    endcase
  endfunction

  function automatic int cnt_of(int i);
    case (i)
      0:       return int'(count_a);
      1:       return int'(count_b);
      default: return int'(count_c);
    endcase
  endfunction

  function automatic int exp_tc(int i);
    int term;
    term = up_dn[i] ? mod_of(i) - 1 : 0;
    return (enable[i] && !load[i] && !clr[i] && m_cnt[i] == term) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int t, m, lv;
      m  = mod_of(i);
      lv = lv_of(i);
      if (clr[i]) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
        m_vld[i] = 1'b1;
      end else begin
        t = exp_tc(i);
        if (load[i]) begin
          m_cnt[i] = (lv >= m) ? m - 1 : lv;
        end else if (enable[i]) begin
          if (up_dn[i])
            m_cnt[i] = (sat_of(i) && m_cnt[i] == m - 1) ? m_cnt[i] : (m_cnt[i] + 1) % m;
          else
            m_cnt[i] = (sat_of(i) && m_cnt[i] == 0) ? 0 : (m_cnt[i] + m - 1) % m;
        end
`ifdef CNT_STICKY_OVF_EN
        if (ovf_clr[i]) m_ovf[i] = 0;
        else if (t != 0) m_ovf[i] = 1;
`else
        m_ovf[i] = t;
`endif
      end
    end
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d want %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Compare every instance against the model once its first clr has landed.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_vld[i]) begin
        check("cnt", i, cnt_of(i), m_cnt[i]);
        check("tc",  i, int'(tc[i]), exp_tc(i));
        check("ovf", i, int'(ovf[i]), m_ovf[i]);
      end
    end
  end

  // Advance n edges; inputs change 10 ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #10;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 3'b111; enable = 3'b000; load = 3'b000; up_dn = 3'b111; ovf_clr = 3'b000;
    lv_a = '0; lv_b = '0; lv_c = '0;

    // 1: reset, then count up from the first enabled edge
    tick(2);
    check("lit_rst_cnt", 0, int'(count_a), 0);
    check("lit_rst_cnt", 1, int'(count_b), 0);
    check("lit_rst_ovf", 0, int'(ovf[0]), 0);
    check("lit_rst_tc",  0, int'(tc[0]), 0);
    clr = 3'b100; enable = 3'b011;
    tick(1);
    check("lit_first", 0, int'(count_a), 1);
    check("lit_first", 1, int'(count_b), 1);
    tick(1);

    // 2: B full wrap 0..9 -> 0
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    tick(9);
    check("lit_b9_cnt", 1, int'(count_b), 9);
    check("lit_b9_tc",  1, int'(tc[1]), 1);
    tick(1);
    check("lit_bwrap_cnt", 1, int'(count_b), 0);
    check("lit_bwrap_ovf", 1, int'(ovf[1]), 1);
    check("lit_bwrap_tc",  1, int'(tc[1]), 0);

    // 3: A enable gap holds the count
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    tick(5);
    check("lit_a5", 0, int'(count_a), 5);
    enable[0] = 1'b0;
    tick(2);
    check("lit_ahold", 0, int'(count_a), 5);
    enable[0] = 1'b1;
    tick(1);
    check("lit_aresume", 0, int'(count_a), 6);

    // 4: B clamped load, then count down through 0 to 9
    load[1] = 1'b1; lv_b = 4'd13;
    tick(1);
    check("lit_clamp", 1, int'(count_b), 9);
    load[1] = 1'b0; up_dn[1] = 1'b0;
    tick(9);
    check("lit_bdn0_cnt", 1, int'(count_b), 0);
    check("lit_bdn0_tc",  1, int'(tc[1]), 1);
    tick(1);
    check("lit_bunder_cnt", 1, int'(count_b), 9);
    check("lit_bunder_ovf", 1, int'(ovf[1]), 1);

    // 5: C saturates at both ends
    clr[2] = 1'b0; load[2] = 1'b1; lv_c = 4'd7; enable[2] = 1'b1;
    tick(1);
    check("lit_c7", 2, int'(count_c), 7);
    load[2] = 1'b0;
    tick(2);
    check("lit_c9_cnt", 2, int'(count_c), 9);
    check("lit_c9_tc",  2, int'(tc[2]), 1);
    tick(2);
    check("lit_csat_cnt", 2, int'(count_c), 9);
    check("lit_csat_ovf", 2, int'(ovf[2]), 1);
    load[2] = 1'b1; lv_c = 4'd1;
    tick(1);
    load[2] = 1'b0; up_dn[2] = 1'b0;
    tick(2);
    check("lit_csat0_cnt", 2, int'(count_c), 0);
    check("lit_csat0_tc",  2, int'(tc[2]), 1);

    // 6: A underflow, overflow, priority of clr, ovf_clr behaviour
    up_dn[0] = 1'b0; load[0] = 1'b1; lv_a = 6'd0;
    tick(1);
    load[0] = 1'b0;
    tick(1);
    check("lit_aunder_cnt", 0, int'(count_a), 63);
    check("lit_aunder_ovf", 0, int'(ovf[0]), 1);
    up_dn[0] = 1'b1; load[0] = 1'b1; lv_a = 6'd62;
    tick(1);
    load[0] = 1'b0;
    tick(2);
    check("lit_awrap_cnt", 0, int'(count_a), 0);
    check("lit_awrap_ovf", 0, int'(ovf[0]), 1);
    enable[0] = 1'b0;
    tick(3);
`ifdef CNT_STICKY_OVF_EN
    check("lit_ahold_ovf", 0, int'(ovf[0]), 1);
`else
    check("lit_ahold_ovf", 0, int'(ovf[0]), 0);
`endif
    load[0] = 1'b1; lv_a = 6'd37;
    tick(1);
    check("lit_a37", 0, int'(count_a), 37);
    clr[0] = 1'b1; enable[0] = 1'b1;
    check("lit_clr_tc", 0, int'(tc[0]), 0);
    tick(1);
    check("lit_clr_cnt", 0, int'(count_a), 0);
    check("lit_clr_ovf", 0, int'(ovf[0]), 0);
    clr[0] = 1'b0; lv_a = 6'd63;
    tick(1);
    load[0] = 1'b0; ovf_clr[0] = 1'b1;
    tick(1);
    check("lit_tie_cnt", 0, int'(count_a), 0);
`ifdef CNT_STICKY_OVF_EN
    check("lit_tie_ovf", 0, int'(ovf[0]), 0);
`else
    check("lit_tie_ovf", 0, int'(ovf[0]), 1);
`endif
    ovf_clr[0] = 1'b0;
    tick(1);
    check("lit_after_cnt", 0, int'(count_a), 1);
    check("lit_after_ovf", 0, int'(ovf[0]), 0);

    @(negedge clk);
    #10;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
